// File: rtl/fir_cmplx_decim.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fir_cmplx_decim                                              |
// | Description : Complex decimating FIR channel filter. Quantized I/Q pairs   |
// |               are shifted into a TAPS-deep delay line; after every DECIM   |
// |               accepted pairs a sequential MAC (one tap per cycle) against  |
// |               one real, runtime-loadable coefficient set produces a single |
// |               dequantized I/Q output pair.                                 |
// | Ports       : clock, reset      - rising-edge clock, async active-high rst |
// |               in_avail/in_rd_en - upstream pair valid / pop request        |
// |               i_in, q_in        - quantized input sample pair              |
// |               coef_wr_en/addr/data - coefficient write port                |
// |               i_out, q_out      - filtered output pair                     |
// |               out_avail/out_rd_en - output valid / downstream pop          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fir_cmplx_decim #(
   parameter int DATA_WIDTH     = 32,
   parameter int QUANTIZE_WIDTH = 10,
   parameter int TAPS           = 20,
   parameter int DECIM          = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_avail,
   input  logic [DATA_WIDTH-1:0]     i_in,
   input  logic [DATA_WIDTH-1:0]     q_in,
   output logic                      in_rd_en,
   input  logic                      coef_wr_en,
   input  logic [$clog2(TAPS)-1:0]   coef_addr,
   input  logic [DATA_WIDTH-1:0]     coef_data,
   output logic [DATA_WIDTH-1:0]     i_out,
   output logic [DATA_WIDTH-1:0]     q_out,
   output logic                      out_avail,
   input  logic                      out_rd_en
);

   localparam int c_TAP_W = $clog2(TAPS);
   localparam int c_CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [c_TAP_W-1:0]    c_TAP_LAST = c_TAP_W'(TAPS - 1);
   localparam logic [c_CNT_W-1:0]    c_CNT_LAST = c_CNT_W'(DECIM - 1);
   // Added to negative products before the arithmetic shift so the shift
   // truncates toward zero instead of toward minus infinity.
   localparam logic [DATA_WIDTH-1:0] c_DEQ_BIAS =
      DATA_WIDTH'((64'd1 << QUANTIZE_WIDTH) - 64'd1);

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic signed [DATA_WIDTH-1:0]    xi_q [TAPS];
   logic signed [DATA_WIDTH-1:0]    xq_q [TAPS];
   logic signed [DATA_WIDTH-1:0]    h_q  [TAPS];
   logic        [c_CNT_W-1:0]       cnt_q;
   logic        [c_TAP_W-1:0]       tap_q;
   logic signed [DATA_WIDTH-1:0]    acc_i_q, acc_q_q;
   logic signed [DATA_WIDTH-1:0]    i_out_q, q_out_q;

   logic                            accept;
   logic                            enter_mac;
   logic                            last_tap;
   logic                            coef_we;
   logic signed [DATA_WIDTH-1:0]    prod_i, prod_q;
   logic signed [DATA_WIDTH-1:0]    sum_i, sum_q;

   function automatic logic signed [DATA_WIDTH-1:0] deq(
      input logic signed [DATA_WIDTH-1:0] p
   );
      logic signed [DATA_WIDTH-1:0] biased;
      biased = p[DATA_WIDTH-1] ? (p + $signed(c_DEQ_BIAS)) : p;
      return biased >>> QUANTIZE_WIDTH;
   endfunction

   // Accept is derived from state rather than in_rd_en so the FSM's
   // next-state logic does not read its own output. Flops are held in reset
   // anyway, so the reset gating on in_rd_en is irrelevant here.
   assign accept    = (state_q == ST_LOAD) && in_avail;
   assign enter_mac = accept && (cnt_q == c_CNT_LAST);
   assign last_tap  = (tap_q == c_TAP_LAST);
   assign coef_we   = coef_wr_en && (int'(coef_addr) < TAPS) &&
                      ((state_q == ST_OUT) || ((state_q == ST_LOAD) && !enter_mac));

   // Products keep only the low DATA_WIDTH bits (self-determined width).
   assign prod_i = xi_q[tap_q] * h_q[tap_q];
   assign prod_q = xq_q[tap_q] * h_q[tap_q];
   assign sum_i  = acc_i_q + deq(prod_i);
   assign sum_q  = acc_q_q + deq(prod_q);

   always_comb begin
      state_d   = state_q;
      in_rd_en  = 1'b0;
      out_avail = 1'b0;
      case (state_q)
         ST_LOAD: begin
            in_rd_en = !reset;
            if (enter_mac) state_d = ST_MAC;
         end
         ST_MAC: begin
            if (last_tap) state_d = ST_OUT;
         end
         ST_OUT: begin
            out_avail = 1'b1;
            if (out_rd_en) state_d = ST_LOAD;
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_LOAD;
         cnt_q   <= '0;
         tap_q   <= '0;
         acc_i_q <= '0;
         acc_q_q <= '0;
         i_out_q <= '0;
         q_out_q <= '0;
         for (int k = 0; k < TAPS; k++) begin
            xi_q[k] <= '0;
            xq_q[k] <= '0;
            h_q[k]  <= '0;
         end
      end else begin
         state_q <= state_d;

         if (coef_we) h_q[coef_addr] <= coef_data;

         if (accept) begin
            xi_q[0] <= i_in;
            xq_q[0] <= q_in;
            for (int k = 1; k < TAPS; k++) begin
               xi_q[k] <= xi_q[k-1];
               xq_q[k] <= xq_q[k-1];
            end
            cnt_q <= enter_mac ? '0 : cnt_q + 1'b1;
         end

         if (enter_mac) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
            tap_q   <= '0;
         end

         if (state_q == ST_MAC) begin
            acc_i_q <= sum_i;
            acc_q_q <= sum_q;
            tap_q   <= tap_q + 1'b1;
            if (last_tap) begin
               i_out_q <= sum_i;
               q_out_q <= sum_q;
            end
         end
      end
   end

   assign i_out = i_out_q;
   assign q_out = q_out_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_cmplx_decim.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fir_cmplx_decim                                           |
// | Description : Directed self-checking bench for fir_cmplx_decim with        |
// |               TAPS=4, DECIM=2, QUANTIZE_WIDTH=10, DATA_WIDTH=32.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fir_cmplx_decim;

   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_avail;
   logic [DW-1:0] i_in, q_in;
   logic          in_rd_en;
   logic          coef_wr_en;
   logic [1:0]    coef_addr;
   logic [DW-1:0] coef_data;
   logic [DW-1:0] i_out, q_out;
   logic          out_avail;
   logic          out_rd_en;

   int n_checks = 0;
   int n_fails  = 0;

   fir_cmplx_decim #(
      .DATA_WIDTH     (32),
      .QUANTIZE_WIDTH (10),
      .TAPS           (4),
      .DECIM          (2)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .in_avail   (in_avail),
      .i_in       (i_in),
      .q_in       (q_in),
      .in_rd_en   (in_rd_en),
      .coef_wr_en (coef_wr_en),
      .coef_addr  (coef_addr),
      .coef_data  (coef_data),
      .i_out      (i_out),
      .q_out      (q_out),
      .out_avail  (out_avail),
      .out_rd_en  (out_rd_en)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic load_coefs(input int h0, input int h1, input int h2, input int h3);
      int h [4];
      h[0] = h0; h[1] = h1; h[2] = h2; h[3] = h3;
      for (int k = 0; k < 4; k++) begin
         coef_wr_en = 1'b1;
         coef_addr  = 2'(k);
         coef_data  = h[k];
         step();
      end
      coef_wr_en = 1'b0;
   endtask

   // Presents one pair and returns one cycle after the accepting edge.
   task automatic push(input int iv, input int qv);
      int n;
      in_avail = 1'b1;
      i_in     = iv;
      q_in     = qv;
      n = 0;
      while (!in_rd_en && n < 100) begin
         step();
         n++;
      end
      chk("push_ready", in_rd_en, 1);
      step();
      in_avail = 1'b0;
   endtask

   task automatic get_output(input string tag, input int ei, input int eq);
      int n;
      n = 0;
      while (!out_avail && n < 100) begin
         step();
         n++;
      end
      chk({tag, "_avail"}, out_avail, 1);
      chk({tag, "_i"}, i_out, ei);
      chk({tag, "_q"}, q_out, eq);
      out_rd_en = 1'b1;
      step();
      out_rd_en = 1'b0;
      in_avail  = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      in_avail   = 1'b0;
      i_in       = '0;
      q_in       = '0;
      coef_wr_en = 1'b0;
      coef_addr  = '0;
      coef_data  = '0;
      out_rd_en  = 1'b0;
      step();
      step();
      chk("rst_in_rd_en", in_rd_en, 0);
      chk("rst_out_avail", out_avail, 0);
      chk("rst_i_out", i_out, 0);
      chk("rst_q_out", q_out, 0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_rd_en", in_rd_en, 1);

      // Impulse response plus latency of the block-completing sample
      load_coefs(1024, 2048, -1024, 512);
      push(1024, -1024);
      push(0, 0);
      for (int c = 1; c <= 4; c++) begin
         chk($sformatf("lat_rd_en_c%0d", c), in_rd_en, 0);
         chk($sformatf("lat_avail_c%0d", c), out_avail, 0);
         step();
      end
      chk("lat_avail_c5", out_avail, 1);
      chk("lat_rd_en_c5", in_rd_en, 0);
      get_output("imp1", 2048, -2048);
      push(0, 0);
      push(0, 0);
      get_output("imp2", 512, -512);

      // Truncation toward zero with h = [1,0,0,0]: output is deq(newest)
      load_coefs(1, 0, 0, 0);
      push(0, 0);  push(-1, -2049);   get_output("trunc1", 0, -2);
      push(0, 0);  push(1023, -1024); get_output("trunc2", 0, -1);
      push(0, 0);  push(2048, -2047); get_output("trunc3", 2, -1);
      push(0, 0);  push(-2048, 3071); get_output("trunc4", -2, 2);

      // Backpressure: delay line i = [300,100,-2048,0], q = [-400,200,3071,0]
      load_coefs(1024, 2048, -1024, 512);
      push(100, 200);
      push(300, -400);
      while (!out_avail) step();
      in_avail = 1'b1;
      i_in     = 999;
      q_in     = 999;
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("bp_rd_en_%0d", c), in_rd_en, 0);
         chk($sformatf("bp_i_%0d", c), i_out, 2548);
         chk($sformatf("bp_q_%0d", c), q_out, -3071);
         step();
      end
      get_output("bp_out", 2548, -3071);
      // Stalled 999 pair must not have entered: i = [-5,1,300,100]
      push(1, -3);
      push(-5, 2047);
      get_output("bp_next", -253, 2541);

      // Coefficient write on the MAC-entering edge and mid-MAC are ignored
      push(0, 0);
      coef_wr_en = 1'b1;
      coef_addr  = 2'd0;
      coef_data  = 4096;
      push(10, -20);
      step();
      step();
      coef_wr_en = 1'b0;
      get_output("cw_mac", 15, -2068);
      // Write in LOAD coincident with a sample accept: both take effect
      coef_wr_en = 1'b1;
      coef_addr  = 2'd0;
      coef_data  = 4096;
      push(0, 0);
      coef_wr_en = 1'b0;
      push(1, 1);
      get_output("cw_load", -6, 24);

      // Reset mid-MAC discards work and clears outputs immediately
      push(0, 0);
      push(1024, -1024);
      step();
      #2;
      reset = 1'b1;
      #1;
      chk("rst_mac_avail", out_avail, 0);
      chk("rst_mac_i", i_out, 0);
      chk("rst_mac_q", q_out, 0);
      chk("rst_mac_rd_en", in_rd_en, 0);
      step();
      reset = 1'b0;
      #1;
      chk("rst_mac_load", in_rd_en, 1);
      load_coefs(1024, 2048, -1024, 512);
      push(1024, -1024);
      push(0, 0);
      get_output("rst_imp1", 2048, -2048);
      push(0, 0);
      push(0, 0);
      get_output("rst_imp2", 512, -512);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
